// File: rtl/sad_pkg.sv
// Shared constants and types for the sub-pel SAD accumulate-and-search stage.
// Candidate index is 5*row + col over the 5x5 half/quarter-pel grid.
package sad_pkg;

   localparam int NCAND        = 25;
   localparam int PIX_PER_LINE = 6;
   localparam int DIFF_W       = 8;
   localparam int LINE_SUM_W   = 11;
   localparam int IDX_W        = 5;

   localparam int ROW_UH = 0;
   localparam int ROW_UQ = 1;
   localparam int ROW_M  = 2;
   localparam int ROW_LQ = 3;
   localparam int ROW_LH = 4;

   localparam int COL_H = 0;
   localparam int COL_Q = 1;
   localparam int COL_F = 2;
   localparam int COL_R = 3;
   localparam int COL_I = 4;

   localparam int CENTRE_IDX = 5 * ROW_M + COL_F;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_SEARCH = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/sad6_line_sum.sv
// Combinational adder tree summing the six 8-bit absolute differences of
// one candidate on one line.
module sad6_line_sum
   import sad_pkg::*;
(
   input  logic [PIX_PER_LINE*DIFF_W-1:0] diff,
   output logic [LINE_SUM_W-1:0]          sum
);

   logic [DIFF_W:0]   pair0;
   logic [DIFF_W:0]   pair1;
   logic [DIFF_W:0]   pair2;
   logic [DIFF_W+1:0] quad;

   assign pair0 = {1'b0, diff[7:0]}   + {1'b0, diff[15:8]};
   assign pair1 = {1'b0, diff[23:16]} + {1'b0, diff[31:24]};
   assign pair2 = {1'b0, diff[39:32]} + {1'b0, diff[47:40]};
   assign quad  = {1'b0, pair0} + {1'b0, pair1};
   assign sum   = {1'b0, quad} + {2'b00, pair2};

endmodule

// File: rtl/sad_best_subpel.sv
// Accumulates 25 candidate SADs over LINES rows, then scans them serially
// (one per cycle) for the minimum, biased so the centre full-pel wins ties.
module sad_best_subpel
   import sad_pkg::*;
#(
   parameter int LINES = 6,
   parameter int ACC_W = 14
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1199:0]         in_diff,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IDX_W-1:0]      best_idx,
   output logic [ACC_W-1:0]      best_sad
);

   localparam int RC_W = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int LINE_W = PIX_PER_LINE * DIFF_W;

   state_t                state;
   logic [RC_W-1:0]       row_cnt;
   logic [IDX_W-1:0]      k;
   logic [LINE_SUM_W-1:0] line_sum [NCAND];
   logic [ACC_W-1:0]      acc      [NCAND];
   logic [ACC_W-1:0]      acc_next [NCAND];
   logic [ACC_W-1:0]      scan_acc;
   logic                  accept;
   logic                  last_line;

   for (genvar c = 0; c < NCAND; c++) begin : g_line_sum
      sad6_line_sum u_sum (
         .diff (in_diff[LINE_W*c +: LINE_W]),
         .sum  (line_sum[c])
      );
   end

   // Row 0 of a block reloads rather than adds, so no explicit clear is needed between blocks.
   always_comb begin
      for (int c = 0; c < NCAND; c++) begin
         acc_next[c] = ((row_cnt == '0) ? '0 : acc[c]) + ACC_W'(line_sum[c]);
      end
   end

   assign accept    = in_ready & in_valid;
   assign last_line = (row_cnt == RC_W'(LINES - 1));
   assign scan_acc  = acc[k];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCAND; c++) acc[c] <= '0;
      end else if (accept) begin
         for (int c = 0; c < NCAND; c++) acc[c] <= acc_next[c];
      end
   end

   // Best is seeded with the centre using its final sum, so the scan only replaces it on a strict improvement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ACCUM;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         best_idx  <= '0;
         best_sad  <= '0;
         row_cnt   <= '0;
         k         <= '0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (accept) begin
                  if (last_line) begin
                     row_cnt  <= '0;
                     state    <= ST_SEARCH;
                     in_ready <= 1'b0;
                     best_idx <= IDX_W'(CENTRE_IDX);
                     best_sad <= acc_next[CENTRE_IDX];
                     k        <= '0;
                  end else begin
                     row_cnt <= row_cnt + RC_W'(1);
                  end
               end
            end
            ST_SEARCH: begin
               if (scan_acc < best_sad) begin
                  best_idx <= k;
                  best_sad <= scan_acc;
               end
               if (k == IDX_W'(NCAND - 1)) begin
                  k         <= '0;
                  state     <= ST_HOLD;
                  out_valid <= 1'b1;
               end else begin
                  k <= k + IDX_W'(1);
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_ACCUM;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_ACCUM;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sad_best_subpel.sv
// Self-checking bench for sad_best_subpel: directed corner blocks plus random
// blocks scored against a per-candidate SAD/minimum model.
module tb_sad_best_subpel;

   localparam int LINES = 6;
   localparam int ACC_W = 14;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1199:0]    in_diff;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       best_idx;
   logic [ACC_W-1:0] best_sad;

   int n_compared;
   int n_mismatched;
   int episodes;
   logic ov_prev;

   logic [1199:0] block_lines [LINES];

   sad_best_subpel #(.LINES(LINES), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_diff   (in_diff),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .best_idx  (best_idx),
      .best_sad  (best_sad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts result episodes (rising out_valid) so spurious results are visible.
   always @(negedge clk) begin
      if (out_valid && !ov_prev) episodes++;
      ov_prev = out_valid;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1199:0] fill_line(input int base, input int special_c, input int special_v);
      logic [1199:0] l;
      for (int c = 0; c < 25; c++)
         for (int p = 0; p < 6; p++)
            l[48*c + 8*p +: 8] = 8'((c == special_c) ? special_v : base);
      return l;
   endfunction

   // Reference: per-candidate totals, then the smallest value with the centre preferred, else lowest index.
   task automatic model(output int e_idx, output int e_sad);
      int sads [25];
      int mn;
      for (int c = 0; c < 25; c++) begin
         sads[c] = 0;
         for (int r = 0; r < LINES; r++)
            for (int p = 0; p < 6; p++)
               sads[c] += int'(block_lines[r][48*c + 8*p +: 8]);
      end
      mn = sads[0];
      for (int c = 1; c < 25; c++) if (sads[c] < mn) mn = sads[c];
      e_sad = mn;
      if (sads[12] == mn) e_idx = 12;
      else begin
         e_idx = -1;
         for (int c = 0; c < 25; c++) if (e_idx < 0 && sads[c] == mn) e_idx = c;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_line(input logic [1199:0] d);
      int budget = 200;
      in_valid = 1'b1;
      in_diff  = d;
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check_output("send_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) check_output("result_timeout", 32'd0, 32'd1);
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_output({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
      check_output({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic apply_stimulus(input string tag, input int exp_idx, input int exp_sad, input bit chk_lat);
      int lat;
      for (int r = 0; r < LINES; r++) send_line(block_lines[r]);
      in_valid = 1'b0;
      wait_result(lat);
      check_output({tag, "_idx"}, 32'(best_idx), 32'(exp_idx));
      check_output({tag, "_sad"}, 32'(best_sad), 32'(exp_sad));
      if (chk_lat) begin
         check_output({tag, "_latency"}, 32'(lat), 32'd25);
         check_output({tag, "_rdy_hold"}, 32'(in_ready), 32'd0);
      end
      release_result(tag);
   endtask

   initial begin
      int e_idx;
      int e_sad;
      int lat;
      int ep0;
      n_compared   = 0;
      n_mismatched = 0;
      episodes     = 0;
      ov_prev      = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_diff   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_in_ready", 32'(in_ready), 32'd1);
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_best_idx", 32'(best_idx), 32'd0);
      check_output("rst_best_sad", 32'(best_sad), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int r = 0; r < LINES; r++) block_lines[r] = fill_line(0, -1, 0);
      apply_stimulus("zeros", 12, 0, 1'b1);

      for (int r = 0; r < LINES; r++) block_lines[r] = fill_line(10, 7, 9);
      apply_stimulus("cand7", 7, 324, 1'b0);

      for (int r = 0; r < LINES; r++) begin
         block_lines[r] = fill_line(8, 3, 5);
         block_lines[r][48*20 +: 48] = {6{8'd5}};
      end
      apply_stimulus("tie_3_20", 3, 180, 1'b0);
      for (int r = 0; r < LINES; r++) block_lines[r][48*12 +: 48] = {6{8'd5}};
      apply_stimulus("tie_centre", 12, 180, 1'b0);

      for (int r = 0; r < LINES; r++) block_lines[r] = fill_line(255, -1, 0);
      apply_stimulus("max", 12, 9180, 1'b0);
      for (int r = 0; r < LINES; r++) block_lines[r] = fill_line(1, -1, 0);
      apply_stimulus("reload", 12, 36, 1'b0);

      // Result held off while upstream presses a new line.
      for (int r = 0; r < LINES; r++)
         for (int c = 0; c < 25; c++)
            for (int p = 0; p < 6; p++)
               block_lines[r][48*c + 8*p +: 8] = 8'($urandom_range(0, 255));
      model(e_idx, e_sad);
      for (int r = 0; r < LINES; r++) send_line(block_lines[r]);
      in_valid = 1'b0;
      wait_result(lat);
      for (int r = 0; r < LINES; r++) block_lines[r] = fill_line(int'($urandom_range(2, 200)), int'($urandom_range(0, 24)), 1);
      in_valid = 1'b1;
      in_diff  = block_lines[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_output("hold_ov", 32'(out_valid), 32'd1);
         check_output("hold_idx", 32'(best_idx), 32'(e_idx));
         check_output("hold_sad", 32'(best_sad), 32'(e_sad));
         check_output("hold_rdy", 32'(in_ready), 32'd0);
      end
      release_result("hold");
      model(e_idx, e_sad);
      apply_stimulus("after_hold", e_idx, e_sad, 1'b0);

      // Reset mid-block: the partial block must leave no trace.
      for (int r = 0; r < 3; r++) send_line(fill_line(0, -1, 0));
      in_valid = 1'b0;
      ep0 = episodes;
      #2 rst_n = 1'b0;
      #1;
      check_output("midrst_rdy", 32'(in_ready), 32'd1);
      check_output("midrst_ov", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int r = 0; r < LINES; r++) block_lines[r] = fill_line(2, 24, 1);
      apply_stimulus("post_rst", 24, 36, 1'b1);
      check_output("post_rst_episodes", 32'(episodes - ep0), 32'd1);

      // Random blocks; odd ones use a tiny byte range to force ties.
      for (int b = 0; b < 8; b++) begin
         for (int r = 0; r < LINES; r++)
            for (int c = 0; c < 25; c++)
               for (int p = 0; p < 6; p++)
                  block_lines[r][48*c + 8*p +: 8] = 8'((b % 2) ? $urandom_range(0, 2) : $urandom_range(0, 255));
         model(e_idx, e_sad);
         apply_stimulus("random", e_idx, e_sad, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
